// File: rtl/seg7_decimal_display_if.sv
// Display request/response bundle between the processor top and the decimal display stage.
// The master issues value/update; the slave reports busy/done and drives the eight digits.
interface seg7_decimal_display_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] value;
  logic             update;
  logic             busy;
  logic             done;
  logic [6:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  modport master (
    output value, update,
    input  busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  value, update,
    output busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/seg7_decimal_display.sv
// Signed decimal 7-segment display with a sequential double-dabble converter.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero magnitude digits.
module seg7_decimal_display #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 7
) (
  input logic                 clk,
  input logic                 rst,
  seg7_decimal_display_if.slave bus
);

  localparam int unsigned ND = DIGITS;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t                 state, state_next;
  logic                   start;
  logic [WIDTH-1:0]       mag, pend_val, src, src_abs;
  logic                   sign, pend, done_q;
  logic [39:0]            bcd, bcd_adj;
  logic [39+WIDTH:0]      shifted;
  logic [5:0]             cnt;
  logic [6:0]             hex_q [8];
  logic [6:0]             hex_d [8];
  logic                   ovf, seen, lz;
  logic [3:0]             digit;
  int unsigned            k;

  // Segment vectors are stored with bit 0 = segment a.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0011000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE:    if (bus.update || pend) begin
                 state_next = SHIFT;
                 start      = 1'b1;
               end
      SHIFT:   if (cnt == 6'(WIDTH - 1)) state_next = ENCODE;
      ENCODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh update in IDLE is the newest request, so it takes priority over a stale pending one.
  assign src     = bus.update ? bus.value : pend_val;
  assign src_abs = src[WIDTH-1] ? ('0 - src) : src;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, mag} << 1;

  always_comb begin
    ovf   = 1'b0;
    seen  = 1'b0;
    lz    = 1'b0;
    k     = 0;
    digit = '0;
    for (int unsigned i = 0; i < 8; i++) hex_d[i] = SEG_BLANK;
    for (int unsigned i = ND; i < 10; i++) ovf = ovf | (bcd[4*i +: 4] != 4'd0);
    for (int unsigned j = 0; j < ND; j++) begin
      k     = ND - 1 - j;
      digit = bcd[4*k +: 4];
      seen  = seen | (digit != 4'd0) | (k == 0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz    = !seen;
`else
      lz    = 1'b0;
`endif
      hex_d[k] = ovf ? SEG_E : (lz ? SEG_BLANK : seg_of(digit));
    end
    hex_d[7] = sign ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      sign     <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) hex_q[i] <= (i < ND) ? SEG_ZERO : SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag  <= src_abs;
          sign <= src[WIDTH-1];
          bcd  <= '0;
          cnt  <= '0;
          pend <= 1'b0;
        end
        SHIFT: begin
          bcd <= shifted[39+WIDTH:WIDTH];
          mag <= shifted[WIDTH-1:0];
          cnt <= cnt + 6'd1;
        end
        ENCODE: begin
          hex_q  <= hex_d;
          done_q <= 1'b1;
        end
        default: ;
      endcase
      if (state != IDLE && bus.update) begin
        pend     <= 1'b1;
        pend_val <= bus.value;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX7 = hex_q[7];

endmodule
